// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Request/response bundle for one requester port of the data-memory arbiter.
// Each requester (core, DMA/debug) gets its own instance.
//
// Signals:
//   req     requester -> arbiter  transfer request, held until granted
//   we      requester -> arbiter  1 = write, 0 = read (valid with req)
//   addr    requester -> arbiter  byte address
//   wdata   requester -> arbiter  write data
//   byteen  requester -> arbiter  byte enables
//   gnt     arbiter -> requester  combinational grant; transfer issues when req && gnt
//   rvalid  arbiter -> requester  registered one-cycle read-data-valid pulse
//   rdata   arbiter -> requester  registered read data, held between reads
//
// Modports: master = requester side, slave = arbiter side.

interface dmem_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [3:0]       byteen;
  logic             gnt;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata, byteen,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, byteen,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter in front of a single data-memory bus. Port 0 is the core,
// port 1 is DMA/debug. Grants are combinational so a transfer issues in the
// same cycle it is requested; an owner may keep the bus for up to MAX_BURST
// consecutive transfers while the other port waits, then must hand over.
// Read data comes back one cycle after issue on the issuing port.
//
// Parameters:
//   WIDTH      data and address width
//   MAX_BURST  max consecutive transfers per owner under contention (1..15)
//
// Ports:
//   clk             sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   p0, p1          requester ports (dmem_arbiter_if.slave)
//   mem_addr_in_o   bus address (0 when no grant)
//   mem_data_in_o   bus write data (0 when no grant)
//   mem_byteen_o    bus byte enables (0 when no grant)
//   mem_read_o      bus read strobe
//   mem_write_o     bus write strobe
//   mem_data_out_i  bus read data, valid combinationally in the issue cycle
//
// Build option:
//   DMEM_ARB_RR_EN  defined: simultaneous requests from IDLE are resolved round
//                   robin on the last granted port (port 0 first after reset).
//                   undefined: port 0 always wins the IDLE tie.

module dmem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    p0,
  dmem_arbiter_if.slave    p1,
  output logic [WIDTH-1:0] mem_addr_in_o,
  output logic [WIDTH-1:0] mem_data_in_o,
  output logic [3:0]       mem_byteen_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  input  logic [WIDTH-1:0] mem_data_out_i
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cnt_inc;
  logic             gnt0, gnt1;
  logic             tie_p0;
  logic             p0_rvalid_q, p1_rvalid_q;
  logic [WIDTH-1:0] p0_rdata_q, p1_rdata_q;

`ifdef DMEM_ARB_RR_EN
  logic lst_q, lst_d;

  // lst holds the last granted port, so a tie goes to the other one.
  assign tie_p0 = lst_q;
`else
  assign tie_p0 = 1'b1;
`endif

  // Saturating burst count for an owner that keeps the bus.
  assign cnt_inc = (cnt_q < MAX_CNT) ? cnt_q + 4'd1 : cnt_q;

  // Grant decision. The owner yields only once its burst is used up and the
  // other port is waiting, or when it stops requesting. Reset masks grants
  // immediately so nothing reaches the bus while rst_n is low.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0.req && p1.req) begin
          gnt0 = tie_p0;
          gnt1 = !tie_p0;
        end else begin
          gnt0 = p0.req;
          gnt1 = p1.req;
        end
      end
      OWN0: begin
        if (p0.req && ((cnt_q < MAX_CNT) || !p1.req)) gnt0 = 1'b1;
        else                                          gnt1 = p1.req;
      end
      OWN1: begin
        if (p1.req && ((cnt_q < MAX_CNT) || !p0.req)) gnt1 = 1'b1;
        else                                          gnt0 = p0.req;
      end
      default: ;
    endcase
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // A cycle without any grant always drops back to IDLE; a grant to a new
  // owner restarts the burst at 1.
  always_comb begin
    state_d = IDLE;
    cnt_d   = 4'd0;
    if (gnt0) begin
      state_d = OWN0;
      cnt_d   = (state_q == OWN0) ? cnt_inc : 4'd1;
    end else if (gnt1) begin
      state_d = OWN1;
      cnt_d   = (state_q == OWN1) ? cnt_inc : 4'd1;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    lst_d = lst_q;
    if (gnt0) lst_d = 1'b0;
    if (gnt1) lst_d = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      lst_q       <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p0_rvalid_q <= gnt0 && !p0.we;
      p1_rvalid_q <= gnt1 && !p1.we;
      if (gnt0 && !p0.we) p0_rdata_q <= mem_data_out_i;
      if (gnt1 && !p1.we) p1_rdata_q <= mem_data_out_i;
`ifdef DMEM_ARB_RR_EN
      lst_q       <= lst_d;
`endif
    end
  end

  // Bus mux: the granted port drives the bus, otherwise everything is zero.
  always_comb begin
    mem_addr_in_o = '0;
    mem_data_in_o = '0;
    mem_byteen_o  = 4'd0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    if (gnt0) begin
      mem_addr_in_o = p0.addr;
      mem_data_in_o = p0.wdata;
      mem_byteen_o  = p0.byteen;
      mem_read_o    = !p0.we;
      mem_write_o   = p0.we;
    end else if (gnt1) begin
      mem_addr_in_o = p1.addr;
      mem_data_in_o = p1.wdata;
      mem_byteen_o  = p1.byteen;
      mem_read_o    = !p1.we;
      mem_write_o   = p1.we;
    end
  end

  assign p0.gnt    = gnt0;
  assign p1.gnt    = gnt1;
  assign p0.rvalid = p0_rvalid_q;
  assign p1.rvalid = p1_rvalid_q;
  assign p0.rdata  = p0_rdata_q;
  assign p1.rdata  = p1_rdata_q;

endmodule
